// File: rtl/vc_credit_tracker_pkg.sv
// Shared router types: port directions, VC id width and the per-VC ownership state.
package vc_credit_tracker_pkg;

  localparam int VC_ID_BITS = 1;

  typedef enum logic [2:0] {
    DIR_NORTH,
    DIR_EAST,
    DIR_SOUTH,
    DIR_WEST,
    DIR_LOCAL
  } dir_t;

  localparam dir_t LOCAL_PORT = DIR_LOCAL;

  // IDLE: allocatable; ACTIVE: packet open; DRAIN: tail sent, waiting for downstream to empty
  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } vc_state_t;

endpackage

// File: rtl/vc_credit_slot.sv
// One VC: downstream free-slot counter plus the ownership FSM, with sim-only protocol checks.
module vc_credit_slot
  import vc_credit_tracker_pkg::*;
#(
  parameter int   FIFO_DEPTH = 4,
  parameter int   CTR_WIDTH  = 3,
  parameter dir_t PORT       = LOCAL_PORT,
  parameter int   VC_IDX     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 send_hit,
  input  logic                 credit_hit,
  input  logic                 send_head,
  input  logic                 send_tail,
  output logic [CTR_WIDTH-1:0] cnt,
  output vc_state_t            state
);

  localparam logic [CTR_WIDTH-1:0] FULL = CTR_WIDTH'(FIFO_DEPTH);

  logic                 dec, inc;
  logic [CTR_WIDTH-1:0] cnt_nxt;

  // A same-cycle send and credit cancel, which keeps both boundaries legal.
  assign dec = send_hit && !credit_hit && (cnt != '0);
  assign inc = credit_hit && !send_hit && (cnt != FULL);

  always_comb begin
    cnt_nxt = cnt;
    if (dec)      cnt_nxt = cnt - CTR_WIDTH'(1);
    else if (inc) cnt_nxt = cnt + CTR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= FULL;
      state <= IDLE;
    end else begin
      cnt <= cnt_nxt;
      case (state)
        IDLE:    if (send_hit && send_head) state <= send_tail ? DRAIN : ACTIVE;
        ACTIVE:  if (send_hit && send_tail) state <= DRAIN;
        // next-cycle count lets the last credit and the release land on one edge
        DRAIN:   if (cnt_nxt == FULL)       state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  int   err_cnt;
  logic e_under, e_over, e_body, e_head, e_drain;

  assign e_under = send_hit && !credit_hit && (cnt == '0);
  assign e_over  = credit_hit && !send_hit && (cnt == FULL);
  assign e_body  = send_hit && (state == IDLE) && !send_head;
  assign e_head  = send_hit && (state == ACTIVE) && send_head;
  assign e_drain = send_hit && (state == DRAIN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (e_under) $display("[%s vc%0d] CREDIT UNDERFLOW (#%0d)", PORT.name(), VC_IDX, err_cnt + 1);
      if (e_over)  $display("[%s vc%0d] CREDIT OVERFLOW (#%0d)", PORT.name(), VC_IDX, err_cnt + 1);
      if (e_body)  $display("[%s vc%0d] BODY ON IDLE VC (#%0d)", PORT.name(), VC_IDX, err_cnt + 1);
      if (e_head)  $display("[%s vc%0d] HEAD ON ACTIVE VC (#%0d)", PORT.name(), VC_IDX, err_cnt + 1);
      if (e_drain) $display("[%s vc%0d] SEND ON DRAINING VC (#%0d)", PORT.name(), VC_IDX, err_cnt + 1);
      err_cnt <= err_cnt + $countones({e_under, e_over, e_body, e_head, e_drain});
    end
  end
`endif

endmodule

// File: rtl/vc_credit_tracker.sv
// Per-output-port credit/VC-state tracker: decodes send and credit VC ids and runs one slot per VC.
module vc_credit_tracker
  import vc_credit_tracker_pkg::*;
#(
  parameter int   NUM_VC     = 2,
  parameter int   FIFO_DEPTH = 4,
  parameter int   CTR_WIDTH  = 3,
  parameter dir_t PORT       = LOCAL_PORT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        send_valid,
  input  logic [VC_ID_BITS-1:0]       send_vc,
  input  logic                        send_head,
  input  logic                        send_tail,
  input  logic                        credit_valid,
  input  logic [VC_ID_BITS-1:0]       credit_vc,
  output logic [NUM_VC*CTR_WIDTH-1:0] credit_count,
  output logic [NUM_VC-1:0]           credit_avail,
  output logic [NUM_VC-1:0]           vc_free
);

  logic [NUM_VC-1:0][CTR_WIDTH-1:0] cnt;
  logic [NUM_VC-1:0]                send_hit, credit_hit;
  vc_state_t                        state [NUM_VC];

  for (genvar v = 0; v < NUM_VC; v++) begin : g_slot
    assign send_hit[v]   = send_valid   && (send_vc   == VC_ID_BITS'(v));
    assign credit_hit[v] = credit_valid && (credit_vc == VC_ID_BITS'(v));

    vc_credit_slot #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .CTR_WIDTH  (CTR_WIDTH),
      .PORT       (PORT),
      .VC_IDX     (v)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .send_hit   (send_hit[v]),
      .credit_hit (credit_hit[v]),
      .send_head  (send_head),
      .send_tail  (send_tail),
      .cnt        (cnt[v]),
      .state      (state[v])
    );

    // pure register decodes; nothing here depends on this cycle's inputs
    assign credit_avail[v] = |cnt[v];
    assign vc_free[v]      = (state[v] == IDLE);
  end

  assign credit_count = cnt;

endmodule

// File: tb/tb_vc_credit_tracker.sv
// Directed vector table plus randomized traffic against a counting reference model.
module tb_vc_credit_tracker;
  import vc_credit_tracker_pkg::*;

  localparam int NV = 2;
  localparam int D  = 4;
  localparam int W  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic send_valid = 1'b0, send_head = 1'b0, send_tail = 1'b0, credit_valid = 1'b0;
  logic [VC_ID_BITS-1:0] send_vc = '0, credit_vc = '0;
  logic [NV*W-1:0] credit_count;
  logic [NV-1:0]   credit_avail, vc_free;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vc_credit_tracker #(.NUM_VC(NV), .FIFO_DEPTH(D), .CTR_WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .send_valid   (send_valid),
    .send_vc      (send_vc),
    .send_head    (send_head),
    .send_tail    (send_tail),
    .credit_valid (credit_valid),
    .credit_vc    (credit_vc),
    .credit_count (credit_count),
    .credit_avail (credit_avail),
    .vc_free      (vc_free)
  );

  typedef struct {
    bit r; bit sv; int svc; bit sh; bit st; bit cv; int cvc;
    int c0; int c1; int av; int fr; int e;
  } vec_t;
  vec_t tbl[$];

  // reference: open-packet and draining flags per VC, plain integer credits
  int m_cnt[NV];
  bit m_open[NV];
  bit m_drain[NV];

  function automatic int dut_errs();
    return dut.g_slot[0].u_slot.err_cnt + dut.g_slot[1].u_slot.err_cnt;
  endfunction

  function automatic int cnt_of(int v);
    return int'(credit_count[v*W +: W]);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic row(input bit r, sv, input int svc, input bit sh, st, cv, input int cvc,
                     input int c0, c1, av, fr, e);
    vec_t x;
    x = '{r, sv, svc, sh, st, cv, cvc, c0, c1, av, fr, e};
    tbl.push_back(x);
  endtask

  // returns number of protocol errors the step should raise
  function automatic int model_step(bit r, bit sv, int svc, bit sh, bit st, bit cv, int cvc);
    int e = 0;
    if (r) begin
      for (int v = 0; v < NV; v++) begin m_cnt[v] = D; m_open[v] = 0; m_drain[v] = 0; end
      return 0;
    end
    for (int v = 0; v < NV; v++) begin
      bit s, c, was_drain;
      int nc;
      s = sv && (svc == v);
      c = cv && (cvc == v);
      was_drain = m_drain[v];
      nc = m_cnt[v] - int'(s) + int'(c);
      if (nc < 0) begin nc = 0; e++; end
      if (nc > D) begin nc = D; e++; end
      if (s) begin
        if (m_drain[v]) e++;
        else if (!m_open[v]) begin
          if (!sh) e++;
          else if (st) m_drain[v] = 1;
          else m_open[v] = 1;
        end else begin
          if (sh) e++;
          if (st) begin m_open[v] = 0; m_drain[v] = 1; end
        end
      end
      if (was_drain && nc == D) m_drain[v] = 0;
      m_cnt[v] = nc;
    end
    return e;
  endfunction

  task automatic drive(input bit r, sv, input int svc, input bit sh, st, cv, input int cvc);
    rst          = r;
    send_valid   = sv;
    send_vc      = VC_ID_BITS'(svc);
    send_head    = sh;
    send_tail    = st;
    credit_valid = cv;
    credit_vc    = VC_ID_BITS'(cvc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // r  sv vc H  T  cv vc | c0 c1 avail  free   err
    row(1, 0, 0, 0, 0, 0, 0,  4, 4, 2'b11, 2'b11, 0);
    row(0, 0, 0, 0, 0, 0, 0,  4, 4, 2'b11, 2'b11, 0);
    row(0, 1, 0, 1, 0, 0, 0,  3, 4, 2'b11, 2'b10, 0);
    row(0, 1, 0, 0, 0, 0, 0,  2, 4, 2'b11, 2'b10, 0);
    row(0, 1, 0, 0, 0, 0, 0,  1, 4, 2'b11, 2'b10, 0);
    row(0, 1, 0, 0, 1, 0, 0,  0, 4, 2'b10, 2'b10, 0);
    row(0, 0, 0, 0, 0, 1, 0,  1, 4, 2'b11, 2'b10, 0);
    row(0, 0, 0, 0, 0, 1, 0,  2, 4, 2'b11, 2'b10, 0);
    row(0, 0, 0, 0, 0, 1, 0,  3, 4, 2'b11, 2'b10, 0);
    row(0, 0, 0, 0, 0, 1, 0,  4, 4, 2'b11, 2'b11, 0);
    row(0, 1, 1, 1, 1, 1, 1,  4, 4, 2'b11, 2'b01, 0);
    row(0, 0, 0, 0, 0, 0, 0,  4, 4, 2'b11, 2'b11, 0);
    row(0, 1, 1, 0, 0, 0, 0,  4, 3, 2'b11, 2'b11, 1);
    row(0, 0, 0, 0, 0, 1, 1,  4, 4, 2'b11, 2'b11, 0);
    row(0, 1, 0, 1, 0, 0, 0,  3, 4, 2'b11, 2'b10, 0);
    row(0, 1, 0, 0, 0, 0, 0,  2, 4, 2'b11, 2'b10, 0);
    row(0, 1, 0, 0, 0, 0, 0,  1, 4, 2'b11, 2'b10, 0);
    row(0, 1, 0, 0, 1, 0, 0,  0, 4, 2'b10, 2'b10, 0);
    row(0, 1, 0, 0, 0, 0, 0,  0, 4, 2'b10, 2'b10, 2);
    row(0, 0, 0, 0, 0, 1, 1,  0, 4, 2'b10, 2'b10, 1);
    row(0, 0, 0, 0, 0, 1, 0,  1, 4, 2'b11, 2'b10, 0);
    row(0, 0, 0, 0, 0, 1, 0,  2, 4, 2'b11, 2'b10, 0);
    row(0, 0, 0, 0, 0, 1, 0,  3, 4, 2'b11, 2'b10, 0);
    row(0, 0, 0, 0, 0, 1, 0,  4, 4, 2'b11, 2'b11, 0);
    row(0, 1, 1, 1, 0, 0, 0,  4, 3, 2'b11, 2'b01, 0);
    row(0, 1, 1, 1, 0, 0, 0,  4, 2, 2'b11, 2'b01, 1);
    row(0, 1, 0, 1, 0, 1, 1,  3, 3, 2'b11, 2'b00, 0);
    row(0, 1, 1, 0, 0, 0, 0,  3, 2, 2'b11, 2'b00, 0);
    row(1, 1, 1, 0, 0, 0, 0,  4, 4, 2'b11, 2'b11, 0);
    row(0, 0, 0, 0, 0, 0, 0,  4, 4, 2'b11, 2'b11, 0);

    foreach (tbl[i]) begin
      int e0, unused_e;
      e0 = dut_errs();
      drive(tbl[i].r, tbl[i].sv, tbl[i].svc, tbl[i].sh, tbl[i].st, tbl[i].cv, tbl[i].cvc);
      unused_e = model_step(tbl[i].r, tbl[i].sv, tbl[i].svc, tbl[i].sh, tbl[i].st, tbl[i].cv, tbl[i].cvc);
      chk($sformatf("row%0d cnt0", i), cnt_of(0), tbl[i].c0);
      chk($sformatf("row%0d cnt1", i), cnt_of(1), tbl[i].c1);
      chk($sformatf("row%0d avail", i), int'(credit_avail), tbl[i].av);
      chk($sformatf("row%0d free", i), int'(vc_free), tbl[i].fr);
      chk($sformatf("row%0d errs", i), dut_errs() - e0, tbl[i].e);
    end

    // randomized traffic: mostly protocol-legal, occasional unconstrained or reset cycles
    for (int n = 0; n < 3000; n++) begin
      bit r, sv, sh, st, cv;
      int svc, cvc, v, e0, exp_e;
      r = ($urandom_range(0, 199) == 0);
      sv = 0; sh = 0; st = 0; cv = 0; svc = 0; cvc = 0;
      if ($urandom_range(0, 15) == 0) begin
        sv = 1'($urandom); svc = $urandom_range(0, NV-1);
        sh = 1'($urandom); st = 1'($urandom);
        cv = 1'($urandom); cvc = $urandom_range(0, NV-1);
      end else begin
        v = $urandom_range(0, NV-1);
        if (m_cnt[v] > 0 && !m_drain[v] && $urandom_range(0, 2) != 0) begin
          sv = 1; svc = v;
          sh = !m_open[v];
          st = ($urandom_range(0, 3) == 0);
        end
        cvc = $urandom_range(0, NV-1);
        if (m_cnt[cvc] < D && $urandom_range(0, 1) == 1) cv = 1;
      end
      e0 = dut_errs();
      drive(r, sv, svc, sh, st, cv, cvc);
      exp_e = model_step(r, sv, svc, sh, st, cv, cvc);
      for (int k = 0; k < NV; k++) begin
        chk($sformatf("rnd%0d cnt%0d", n, k), cnt_of(k), m_cnt[k]);
        chk($sformatf("rnd%0d avail%0d", n, k), int'(credit_avail[k]), int'(m_cnt[k] != 0));
        chk($sformatf("rnd%0d free%0d", n, k), int'(vc_free[k]), int'(!m_open[k] && !m_drain[k]));
      end
      chk($sformatf("rnd%0d errs", n), dut_errs() - e0, exp_e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
